// File: rtl/kernel_top_coriolis_ker0_0_ostream_pack.sv
// Packs PACK stream elements per output word into a DEPTH-entry FIFO.
// Optional STREAM_ELEM_COUNT_EN adds an elem_count port counting accepted elements.
module kernel_top_coriolis_ker0_0_ostream_pack #(
  parameter int STREAMW = 34,
  parameter int PACK    = 2,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ivalid_in1_s0,
  input  logic [STREAMW-1:0]        in1_s0,
  output logic                      iready,
  input  logic                      flush,
  output logic                      ovalid_out1_s0,
  output logic [STREAMW*PACK-1:0]   out1_s0,
  input  logic                      oready_out1_s0
`ifdef STREAM_ELEM_COUNT_EN
  ,
  output logic [31:0]               elem_count
`endif
);

  localparam int WORDW = STREAMW * PACK;
  localparam int LANEW = $clog2(PACK);
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = PTRW + 1;
  localparam logic [LANEW-1:0] LAST_LANE  = LANEW'(PACK - 1);
  localparam logic [CNTW-1:0]  FULL_COUNT = CNTW'(DEPTH);

  logic [WORDW-1:0] fifo_mem [DEPTH];
  logic [PTRW-1:0]  rd_ptr_reg;
  logic [PTRW-1:0]  wr_ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic [CNTW-1:0]  count_next;
  logic [LANEW-1:0] lane_reg;
  logic [LANEW-1:0] lane_next;
  logic [LANEW-1:0] lane_acc;
  logic [WORDW-1:0] word_reg;
  logic [WORDW-1:0] word_merged;
  logic [WORDW-1:0] push_word;
  logic             flush_pending_reg;
  logic             flush_pending_next;

  logic accept;
  logic pop;
  logic push;
  logic word_done;
  logic flush_push;
  logic has_room;

  assign has_room       = count_reg < FULL_COUNT;
  assign iready         = has_room && !flush_pending_reg;
  assign accept         = ivalid_in1_s0 && iready;
  assign ovalid_out1_s0 = count_reg != '0;
  assign pop            = ovalid_out1_s0 && oready_out1_s0;
  assign out1_s0        = fifo_mem[rd_ptr_reg];

  // Writing lane 0 starts a new word, so all higher lanes are cleared; a
  // flushed partial word therefore carries zeros in its unfilled lanes.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign word_merged[gi*STREAMW +: STREAMW] =
        (accept && lane_reg == LANEW'(gi)) ? in1_s0 :
        (accept && lane_reg == '0)         ? '0     :
                                             word_reg[gi*STREAMW +: STREAMW];
    end
  endgenerate

  assign word_done  = accept && (lane_reg == LAST_LANE);
  assign flush_push = flush_pending_reg && has_room;
  assign push       = word_done || flush_push;
  assign push_word  = flush_push ? word_reg : word_merged;

  always_comb begin
    lane_acc = lane_reg;
    if (accept) begin
      lane_acc = word_done ? '0 : lane_reg + 1'b1;
    end
    lane_next = flush_push ? '0 : lane_acc;
  end

  // Flush looks at the lane after any same-cycle element, so a flush that
  // arrives with the completing element produces no extra word.
  always_comb begin
    flush_pending_next = flush_pending_reg;
    if (flush_push) begin
      flush_pending_next = 1'b0;
    end else if (flush && !flush_pending_reg && lane_acc != '0) begin
      flush_pending_next = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      lane_reg          <= '0;
      word_reg          <= '0;
      flush_pending_reg <= 1'b0;
    end else begin
      count_reg         <= count_next;
      lane_reg          <= lane_next;
      flush_pending_reg <= flush_pending_next;
      if (accept) begin
        word_reg <= word_merged;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Storage is not reset; occupancy is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr_reg] <= push_word;
    end
  end

`ifdef STREAM_ELEM_COUNT_EN
  logic [31:0] elem_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_count_reg <= '0;
    end else if (accept) begin
      elem_count_reg <= elem_count_reg + 32'd1;
    end
  end

  assign elem_count = elem_count_reg;
`endif

endmodule
